// File: rtl/q_pkg.sv
// rtl/q_pkg.sv - shared widths, sentinel index and FSM encoding for the Q-argmax controller
package q_pkg;

    localparam int Q_W     = 16;
    localparam int N_CELLS = 9;
    localparam int IDX_W   = 4;

    localparam logic [IDX_W-1:0] NO_MOVE_IDX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/q_cmp_stage.sv
// rtl/q_cmp_stage.sv - running-maximum candidate register with lowest-index tie break
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear            drop the current candidate (start of a new scan)
//   valid            value/index present a legal cell this cycle
//   value, index     cell Q-value (unsigned) and its cell index
//   best_val         best value including this cycle's input
//   best_idx         index of best_val (NO_MOVE_IDX when nothing found)
//   found            at least one legal cell seen, including this cycle
module q_cmp_stage #(
    parameter int Q_W   = q_pkg::Q_W,
    parameter int IDX_W = q_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [Q_W-1:0]   value,
    input  logic [IDX_W-1:0] index,
    output logic [Q_W-1:0]   best_val,
    output logic [IDX_W-1:0] best_idx,
    output logic             found
);

    import q_pkg::*;

    logic [Q_W-1:0]   cand_val_q, cand_val_d;
    logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
    logic             found_q,    found_d;
    logic             take;

    // First legal cell is taken regardless of value; later ones only when
    // strictly greater, so equal values keep the earlier (lower) index.
    assign take = valid && (!found_q || (value > cand_val_q));

    // Outputs already merge the current input so the controller can latch the
    // final result in the same cycle the last data word arrives.
    always_comb begin
        best_val = take ? value : cand_val_q;
        best_idx = take ? index : cand_idx_q;
        found    = found_q | valid;
    end

    always_comb begin
        cand_val_d = best_val;
        cand_idx_d = best_idx;
        found_d    = found;
        if (clear) begin
            cand_val_d = '0;
            cand_idx_d = NO_MOVE_IDX;
            found_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_val_q <= '0;
            cand_idx_q <= NO_MOVE_IDX;
            found_q    <= 1'b0;
        end else begin
            cand_val_q <= cand_val_d;
            cand_idx_q <= cand_idx_d;
            found_q    <= found_d;
        end
    end

endmodule

// File: rtl/q_argmax_ctrl.sv
// rtl/q_argmax_ctrl.sv - scans Q-memory over legal cells and reports the argmax action
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request one scan (ignored while busy)
//   board_occ        occupied mask, bit i=1 makes action i illegal
//   q_rd_en, q_addr  Q-memory read strobe and cell address
//   q_rdata          Q-memory data, valid one cycle after q_rd_en
//   busy             scan in progress (through the done cycle)
//   done             one-cycle completion pulse
//   best_idx, best_q selected action and its Q-value
//   no_move          no legal action was available
module q_argmax_ctrl #(
    parameter int Q_W     = q_pkg::Q_W,
    parameter int N_CELLS = q_pkg::N_CELLS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_CELLS-1:0]      board_occ,
    output logic                    q_rd_en,
    output logic [q_pkg::IDX_W-1:0] q_addr,
    input  logic [Q_W-1:0]          q_rdata,
    output logic                    busy,
    output logic                    done,
    output logic [q_pkg::IDX_W-1:0] best_idx,
    output logic [Q_W-1:0]          best_q,
    output logic                    no_move
);

    import q_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

    state_t             state_q,   state_d;
    logic [IDX_W-1:0]   cnt_q,     cnt_d;
    logic [N_CELLS-1:0] occ_q,     occ_d;
    logic               rd_vld_q,  rd_vld_d;
    logic [IDX_W-1:0]   rd_idx_q,  rd_idx_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic [Q_W-1:0]     res_val_q, res_val_d;
    logic               no_move_q, no_move_d;

    logic               cmp_clear;
    logic               cmp_valid;
    logic [Q_W-1:0]     cmp_best_val;
    logic [IDX_W-1:0]   cmp_best_idx;
    logic               cmp_found;

    assign cmp_clear = (state_q == ST_IDLE) && start;
    // rd_vld_q/rd_idx_q track the read issued last cycle, which lines up with
    // q_rdata; the occupancy mask latched at start decides legality.
    assign cmp_valid = rd_vld_q && !occ_q[rd_idx_q];

    q_cmp_stage #(
        .Q_W   (Q_W),
        .IDX_W (IDX_W)
    ) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cmp_clear),
        .valid    (cmp_valid),
        .value    (q_rdata),
        .index    (rd_idx_q),
        .best_val (cmp_best_val),
        .best_idx (cmp_best_idx),
        .found    (cmp_found)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        occ_d     = occ_q;
        rd_vld_d  = 1'b0;
        rd_idx_d  = cnt_q;
        res_idx_d = res_idx_q;
        res_val_d = res_val_q;
        no_move_d = no_move_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    occ_d   = board_occ;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                rd_vld_d = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Final data word is on q_rdata now; the comparator's merged
                // outputs already include it, so the result becomes visible
                // exactly in the done cycle.
                state_d   = ST_DONE;
                res_idx_d = cmp_found ? cmp_best_idx : NO_MOVE_IDX;
                res_val_d = cmp_found ? cmp_best_val : '0;
                no_move_d = !cmp_found;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            occ_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            res_idx_q <= NO_MOVE_IDX;
            res_val_q <= '0;
            no_move_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            occ_q     <= occ_d;
            rd_vld_q  <= rd_vld_d;
            rd_idx_q  <= rd_idx_d;
            res_idx_q <= res_idx_d;
            res_val_q <= res_val_d;
            no_move_q <= no_move_d;
        end
    end

    assign q_rd_en  = (state_q == ST_SCAN);
    assign q_addr   = q_rd_en ? cnt_q : '0;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign best_idx = res_idx_q;
    assign best_q   = res_val_q;
    assign no_move  = no_move_q;

endmodule

// File: tb/tb_q_argmax_ctrl.sv
// tb/tb_q_argmax_ctrl.sv - scoreboard bench for q_argmax_ctrl
module tb_q_argmax_ctrl;

    localparam int Q_W     = 16;
    localparam int N_CELLS = 9;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [N_CELLS-1:0] board_occ;
    logic               q_rd_en;
    logic [3:0]         q_addr;
    logic [Q_W-1:0]     q_rdata;
    logic               busy;
    logic               done;
    logic [3:0]         best_idx;
    logic [Q_W-1:0]     best_q;
    logic               no_move;

    q_argmax_ctrl #(
        .Q_W     (Q_W),
        .N_CELLS (N_CELLS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .board_occ (board_occ),
        .q_rd_en   (q_rd_en),
        .q_addr    (q_addr),
        .q_rdata   (q_rdata),
        .busy      (busy),
        .done      (done),
        .best_idx  (best_idx),
        .best_q    (best_q),
        .no_move   (no_move)
    );

    typedef struct {
        logic [3:0]     idx;
        logic [Q_W-1:0] val;
        logic           nm;
        int             cyc;
    } exp_t;

    exp_t           sb_q[$];
    logic [Q_W-1:0] mem [N_CELLS];
    int             cyc;
    int             n_tests;
    int             n_fail;
    int             done_seen;
    int             rd_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle read latency; garbage when not reading so stray captures show up.
    always @(posedge clk) begin
        if (q_rd_en) q_rdata <= mem[q_addr];
        else         q_rdata <= 16'($urandom);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [N_CELLS-1:0] occ);
        exp_t e;
        logic found;
        found = 1'b0;
        e.idx = 4'hF;
        e.val = '0;
        e.nm  = 1'b0;
        e.cyc = 0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (!occ[i] && (!found || mem[i] > e.val)) begin
                found = 1'b1;
                e.idx = 4'(i);
                e.val = mem[i];
            end
        end
        e.nm = !found;
        return e;
    endfunction

    // Monitor: address sequence and done-time comparison against the scoreboard.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt = 0;
        end else begin
            if (q_rd_en) begin
                check_eq("q_addr_seq", 32'(q_addr), 32'(rd_cnt));
                rd_cnt = rd_cnt + 1;
            end
            if (done) begin
                done_seen = done_seen + 1;
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("best_idx", 32'(best_idx), 32'(e.idx));
                    check_eq("best_q",   32'(best_q),   32'(e.val));
                    check_eq("no_move",  32'(no_move),  32'(e.nm));
                    check_eq("done_cyc", 32'(cyc),      32'(e.cyc));
                    check_eq("busy_at_done", 32'(busy), 32'd1);
                    check_eq("rd_count", 32'(rd_cnt),   32'(N_CELLS));
                end
                rd_cnt = 0;
            end
        end
    end

    task automatic wait_done(input int prev_seen);
        int budget;
        budget = 30;
        while (done_seen == prev_seen && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (done_seen == prev_seen) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    // Drives start in the cycle right after the previous done (back-to-back),
    // scrambles board_occ after the start edge, optionally re-pulses start.
    task automatic do_scan(input logic [N_CELLS-1:0] occ, input bit repulse);
        exp_t e;
        int   prev;
        @(negedge clk);
        #1;
        check_eq("idle_done_low", 32'(done), 32'd0);
        check_eq("idle_not_busy", 32'(busy), 32'd0);
        e       = model(occ);
        e.cyc   = cyc + 11;
        prev    = done_seen;
        sb_q.push_back(e);
        board_occ = occ;
        start     = 1'b1;
        @(negedge clk);
        #1;
        start     = 1'b0;
        board_occ = N_CELLS'($urandom);
        check_eq("busy_in_scan", 32'(busy), 32'd1);
        if (repulse) begin
            repeat (2) @(negedge clk);
            #1;
            start = 1'b1;
            @(negedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(prev);
    endtask

    task automatic load_mem(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
        mem[0] = 16'(v0); mem[1] = 16'(v1); mem[2] = 16'(v2);
        mem[3] = 16'(v3); mem[4] = 16'(v4); mem[5] = 16'(v5);
        mem[6] = 16'(v6); mem[7] = 16'(v7); mem[8] = 16'(v8);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        done_seen = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        board_occ = '0;
        load_mem(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #13;
        check_eq("rst_busy",     32'(busy),     32'd0);
        check_eq("rst_done",     32'(done),     32'd0);
        check_eq("rst_rd_en",    32'(q_rd_en),  32'd0);
        check_eq("rst_addr",     32'(q_addr),   32'd0);
        check_eq("rst_best_idx", 32'(best_idx), 32'hF);
        check_eq("rst_best_q",   32'(best_q),   32'd0);
        check_eq("rst_no_move",  32'(no_move),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load_mem(1, 212, 3, 4, 5, 6, 7, 8, 9);
        do_scan(9'b000000000, 1'b0);
        do_scan(9'b000000010, 1'b0);
        load_mem(1, 22, 3, 45, 5, 6, 7, 8, 9);
        do_scan(9'b000000000, 1'b0);
        load_mem(5, 5, 5, 5, 5, 5, 5, 5, 5);
        do_scan(9'b000000001, 1'b0);
        do_scan(9'h1FF, 1'b0);
        load_mem(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_scan(9'b000000000, 1'b0);
        load_mem(3, 7, 65535, 7, 2, 65535, 0, 1, 9);
        do_scan(9'b000000100, 1'b1);
        check_eq("single_done_after_repulse", 32'(sb_q.size()), 32'd0);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N_CELLS; i++) mem[i] = 16'($urandom_range(0, 15));
            do_scan(N_CELLS'($urandom), 1'b0);
        end

        // Abort mid-scan with reset, then a fresh scan must be correct.
        load_mem(10, 20, 30, 40, 50, 60, 70, 80, 90);
        @(negedge clk);
        #1;
        sb_q.push_back(model('0));
        board_occ = '0;
        start     = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_rd_en",    32'(q_rd_en),  32'd0);
        check_eq("abort_busy",     32'(busy),     32'd0);
        check_eq("abort_done",     32'(done),     32'd0);
        check_eq("abort_best_idx", 32'(best_idx), 32'hF);
        sb_q.delete();
        begin
            int seen;
            seen = done_seen;
            repeat (3) @(negedge clk);
            check_eq("abort_no_done", 32'(done_seen), 32'(seen));
        end
        rst_n = 1'b1;
        load_mem(4, 3, 2, 1, 0, 9, 8, 7, 6);
        do_scan(9'b000100000, 1'b0);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/q_argmax_ctrl.md
Q_ARGMAX_CTRL -- requirements
Module: q_argmax_ctrl

Interface
REQ-001 SHALL have parameter Q_W, default 16: Q-value width in bits.
REQ-002 SHALL have parameter N_CELLS, default 9: number of board cells/actions scanned.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request one argmax scan.
REQ-006 SHALL have port board_occ, input, N_CELLS bits: occupied-cell mask; bit i=1 means action i is illegal.
REQ-007 SHALL have port q_rd_en, output, 1 bit: Q-memory read strobe.
REQ-008 SHALL have port q_addr, output, 4 bits: Q-memory cell address, 0..N_CELLS-1.
REQ-009 SHALL have port q_rdata, input, Q_W bits: Q-memory data, valid exactly one cycle after q_rd_en.
REQ-010 SHALL have port busy, output, 1 bit: scan in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port best_idx, output, 4 bits: index of the selected legal action.
REQ-013 SHALL have port best_q, output, Q_W bits: Q-value of the selected action.
REQ-014 SHALL have port no_move, output, 1 bit: no legal action exists.

Function
REQ-015 SHALL implement states IDLE, SCAN, DRAIN and DONE.
REQ-016 SHALL, in IDLE with start=1 at edge T, latch board_occ, clear the running maximum and enter SCAN.
REQ-017 SHALL assert q_rd_en in cycles T+1..T+N_CELLS with q_addr = 0,1,...,N_CELLS-1 in order, and hold q_rd_en=0 and q_addr=0 at all other times.
REQ-018 SHALL enter DRAIN after the last read is issued, for one cycle, to capture the final q_rdata.
REQ-019 SHALL assert done for exactly cycle T+N_CELLS+2 (T+11 for the default), then return to IDLE.
REQ-020 SHALL hold busy=1 from T+1 through the done cycle inclusive.
REQ-021 SHALL compare q_rdata as unsigned Q_W-bit values.
REQ-022 SHALL ignore the data of any cell whose latched occ bit is 1.
REQ-023 SHALL update the candidate only when strictly greater than the current candidate, so ties resolve to the lowest index.
REQ-024 SHALL select the first legal cell unconditionally, including when its Q-value is 0.
REQ-025 SHALL, when all latched occ bits are 1, produce no_move=1, best_idx=4'hF and best_q=0.
REQ-026 SHALL update best_idx, best_q and no_move only in the done cycle, and hold them stable until the next done.
REQ-027 SHALL ignore start while busy=1; start SHALL NOT be queued.
REQ-028 SHALL have no effect from board_occ changes after the start edge on the current scan.
REQ-029 SHALL accept a start asserted in the cycle after done (back-to-back operation).

Reset
REQ-030 SHALL, while rst_n=0, force IDLE with busy=0, done=0, q_rd_en=0, q_addr=0, best_idx=4'hF, best_q=0 and no_move=0, regardless of clk.
REQ-031 SHALL abort a scan in progress when reset is asserted, with no done pulse and no result update.
REQ-032 SHALL resume on the first clk edge after rst_n deasserts, with start sampled from that edge.

Structure
REQ-033 SHALL take Q_W, N_CELLS, IDX_W=4, NO_MOVE_IDX=4'hF and the state encoding from a shared package q_pkg.
REQ-034 SHALL contain the comparator/candidate register as one sub-module, q_cmp_stage: inputs are value, index, valid and clear; outputs are best value, best index and found.
REQ-035 SHALL keep the FSM and address counter in q_argmax_ctrl itself.

Verification
REQ-036 SHALL cover: occ=0, memory {1,212,3,4,5,6,7,8,9} -> done at T+11 with best_idx=1, best_q=212, no_move=0.
REQ-037 SHALL cover: the same memory with occ=9'b000000010 -> best_idx=8, best_q=9; then memory {1,22,3,45,5,6,7,8,9} with occ=0 -> best_idx=3, best_q=45.
REQ-038 SHALL cover: all cells equal 5, occ=9'b000000001 -> best_idx=1, best_q=5 (tie goes to the lowest legal index).
REQ-039 SHALL cover: occ=9'h1FF -> no_move=1, best_idx=4'hF, best_q=0, done at T+11.
REQ-040 SHALL cover: start re-pulsed at T+4 -> exactly one done, at T+11, and the address sequence 0..8 unbroken.
REQ-041 SHALL cover: rst_n low at T+5 -> q_rd_en=0 and busy=0 immediately with no done, and a fresh start after release produces a correct result.
